// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
// Contents: FSM state enum, requester id enum, requester count, LAT bounds,
//           LAT legality helper and round-robin successor helper.
// Optional feature macro used by the arbiter: MEM_ARB_RR_EN (round-robin).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_IF = 2'd0,
    REQ_DM = 2'd1,
    REQ_LD = 2'd2
  } req_id_e;

  localparam int NREQ    = 3;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  // True when an access latency fits the 4-bit down-counter.
  function automatic bit lat_legal(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

  // Round-robin successor in the order IF -> DM -> LD -> IF.
  function automatic req_id_e next_req(input req_id_e id);
    case (id)
      REQ_IF:  return REQ_DM;
      REQ_DM:  return REQ_LD;
      default: return REQ_IF;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection among IF/DM/LD requests.
// Ports: req_i (bit index = requester id), ptr_i (last granted id),
//        vld_o (some request present), id_o (winning requester).
// MEM_ARB_RR_EN defined: round-robin starting after ptr_i; undefined: LD > DM > IF.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  req_id_e         ptr_i,
  output logic            vld_o,
  output req_id_e         id_o
);

`ifdef MEM_ARB_RR_EN
  req_id_e c1, c2, c3;

  always_comb begin
    c1    = next_req(ptr_i);
    c2    = next_req(c1);
    c3    = next_req(c2);
    vld_o = |req_i;
    id_o  = REQ_IF;
    if (req_i[c1])      id_o = c1;
    else if (req_i[c2]) id_o = c2;
    else if (req_i[c3]) id_o = c3;
  end
`else
  // Fixed priority has no notion of history; the pointer is ignored.
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    vld_o = |req_i;
    id_o  = REQ_IF;
    if (req_i[int'(REQ_LD)])      id_o = REQ_LD;
    else if (req_i[int'(REQ_DM)]) id_o = REQ_DM;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory between instruction fetch (IF),
// data (DM) and program loader (LD) ports; one LAT-cycle access per grant,
// then a one-cycle ack with read data held in per-port rdata registers.
// Ports: clk, rst_n (async active-low), if_*/dm_*/ld_* requester ports,
//        mem_* memory port, busy (high in ACCESS and RESP).
// Optional feature macro: MEM_ARB_RR_EN (round-robin IF->DM->LD instead of LD>DM>IF).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // An out-of-range LAT degenerates to single-cycle accesses.
  localparam logic [3:0] LAT_LOAD = lat_legal(LAT) ? 4'(LAT - 1) : 4'd0;

  arb_state_e    state_q, state_d;
  req_id_e       id_q, id_d;
  logic          we_q, we_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;

  logic          pick_vld;
  req_id_e       pick_id;
  req_id_e       ptr_sel;

`ifdef MEM_ARB_RR_EN
  req_id_e ptr_q, ptr_d;
  assign ptr_sel = ptr_q;
`else
  assign ptr_sel = REQ_IF;
`endif

  mem_arb_pick u_pick (
    .req_i ({ld_req, dm_req, if_req}),
    .ptr_i (ptr_sel),
    .vld_o (pick_vld),
    .id_o  (pick_id)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          id_d    = pick_id;
          cnt_d   = LAT_LOAD;
          state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
          ptr_d   = pick_id;
`endif
          case (pick_id)
            REQ_LD: begin
              addr_d  = ld_addr;
              wdata_d = ld_wdata;
              we_d    = 1'b1;
            end
            REQ_DM: begin
              addr_d  = dm_addr;
              wdata_d = dm_wdata;
              we_d    = dm_we;
            end
            default: begin
              // Fetch carries no store data; the write-data register keeps its value.
              addr_d  = if_addr;
              we_d    = 1'b0;
            end
          endcase
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last access cycle: memory read data is valid now.
          if (!we_q) begin
            if (id_q == REQ_IF) if_rdata_d = mem_rdata;
            if (id_q == REQ_DM) dm_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= REQ_IF;
      we_q       <= 1'b0;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      ptr_q      <= REQ_IF;
`endif
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // Control outputs decode straight from state so a reset drops them at once.
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign if_ack    = (state_q == RESP) && (id_q == REQ_IF);
  assign dm_ack    = (state_q == RESP) && (id_q == REQ_DM);
  assign ld_ack    = (state_q == RESP) && (id_q == REQ_LD);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with LAT=2.
// Inputs change 1ns after a rising edge; outputs are sampled at that point too.
// Expected grant order depends on MEM_ARB_RR_EN.
module tb_mem_port_arbiter;
  logic        clk;
  logic        rst_n;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        ld_req, ld_ack;
  logic [31:0] ld_addr, ld_wdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Runs until any ack (bounded); reports mem_en/mem_we cycles, cycles taken,
  // ack vector {ld,dm,if} and the address/data seen on the first enabled cycle.
  task automatic xfer(output int en_cnt, output int we_cnt, output int lat,
                      output logic [2:0] acks, output logic [31:0] a_seen,
                      output logic [31:0] d_seen);
    en_cnt = 0; we_cnt = 0; lat = 0; acks = 3'b000; a_seen = '0; d_seen = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_en) begin
        if (en_cnt == 0) begin
          a_seen = mem_addr;
          d_seen = mem_wdata;
        end
        en_cnt++;
      end
      if (mem_we) we_cnt++;
      if (if_ack || dm_ack || ld_ack) begin
        acks = {ld_ack, dm_ack, if_ack};
        lat  = i;
        break;
      end
    end
    if (lat == 0) chk("ack_timeout", 32'(lat), 32'd1);
  endtask

  int          en, we, lat;
  logic [2:0]  acks;
  logic [31:0] a_s, d_s;
  logic [2:0]  exp_ack [3];
  int          exp_we  [3];

  initial begin
    rst_n = 1'b0;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    ld_req = 0; ld_addr = 0; ld_wdata = 0; mem_rdata = 0;
    tick();
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_acks", 32'({ld_ack, dm_ack, if_ack}), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Instruction fetch
    if_req = 1; if_addr = 32'h10; mem_rdata = 32'h8C010004;
    tick();
    chk("if_en_c1", 32'(mem_en), 1);
    chk("if_we_c1", 32'(mem_we), 0);
    chk("if_addr_c1", mem_addr, 32'h10);
    chk("if_busy_c1", 32'(busy), 1);
    tick();
    chk("if_en_c2", 32'(mem_en), 1);
    chk("if_ack_c2", 32'(if_ack), 0);
    tick();
    chk("if_en_resp", 32'(mem_en), 0);
    chk("if_ack_c3", 32'(if_ack), 1);
    chk("if_rdata", if_rdata, 32'h8C010004);
    if_req = 0;
    tick();
    chk("if_ack_drop", 32'(if_ack), 0);
    chk("if_idle_busy", 32'(busy), 0);
    chk("if_rdata_hold", if_rdata, 32'h8C010004);

    // Data store
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; mem_rdata = 32'h12345678;
    xfer(en, we, lat, acks, a_s, d_s);
    chk("st_en_cycles", 32'(en), 2);
    chk("st_we_cycles", 32'(we), 2);
    chk("st_latency", 32'(lat), 3);
    chk("st_ack", 32'(acks), 32'b010);
    chk("st_addr", a_s, 32'h40);
    chk("st_wdata", d_s, 32'hDEADBEEF);
    chk("st_dm_rdata", dm_rdata, 0);
    dm_req = 0;
    tick();
    chk("st_addr_hold", mem_addr, 32'h40);

    // Data load
    dm_req = 1; dm_we = 0; dm_addr = 32'h44; mem_rdata = 32'hCAFEF00D;
    xfer(en, we, lat, acks, a_s, d_s);
    chk("ld_ack_dm", 32'(acks), 32'b010);
    chk("ld_we_cycles", 32'(we), 0);
    chk("ld_dm_rdata", dm_rdata, 32'hCAFEF00D);
    chk("ld_if_untouched", if_rdata, 32'h8C010004);
    dm_req = 0;
    tick();

    // IF + DM together from reset pointer: DM first in both modes
    do_reset();
    if_req = 1; if_addr = 32'h14; dm_req = 1; dm_we = 0; dm_addr = 32'h48; mem_rdata = 32'h77778888;
    xfer(en, we, lat, acks, a_s, d_s);
    chk("pair_first", 32'(acks), 32'b010);
    chk("pair_first_addr", a_s, 32'h48);
    dm_req = 0;
    tick();
    chk("pair_gap_busy", 32'(busy), 0);
    xfer(en, we, lat, acks, a_s, d_s);
    chk("pair_second", 32'(acks), 32'b001);
    chk("pair_second_lat", 32'(lat), 3);
    chk("pair_if_rdata", if_rdata, 32'h77778888);
    if_req = 0;
    tick();

    // All three held continuously
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_ack[0] = 3'b010; exp_ack[1] = 3'b100; exp_ack[2] = 3'b001;
    exp_we[0]  = 0;      exp_we[1]  = 2;      exp_we[2]  = 0;
`else
    exp_ack[0] = 3'b100; exp_ack[1] = 3'b100; exp_ack[2] = 3'b100;
    exp_we[0]  = 2;      exp_we[1]  = 2;      exp_we[2]  = 2;
`endif
    if_req = 1; if_addr = 32'h18; dm_req = 1; dm_we = 0; dm_addr = 32'h4C;
    ld_req = 1; ld_addr = 32'h100; ld_wdata = 32'hAAAA5555; mem_rdata = 32'h5A5A5A5A;
    for (int k = 0; k < 3; k++) begin
      xfer(en, we, lat, acks, a_s, d_s);
      chk($sformatf("all_ack_%0d", k), 32'(acks), 32'(exp_ack[k]));
      chk($sformatf("all_we_%0d", k), 32'(we), 32'(exp_we[k]));
    end
    if_req = 0; dm_req = 0; ld_req = 0;
    tick();
    tick();

    // Reset during the second access cycle
    if_req = 1; if_addr = 32'h20; mem_rdata = 32'h11112222;
    tick();
    tick();
    chk("ab_en_before", 32'(mem_en), 1);
    rst_n = 1'b0;
    #1;
    chk("ab_en_dropped", 32'(mem_en), 0);
    chk("ab_no_ack", 32'({ld_ack, dm_ack, if_ack}), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_if_rdata", if_rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    xfer(en, we, lat, acks, a_s, d_s);
    chk("ab_restart_ack", 32'(acks), 32'b001);
    chk("ab_restart_lat", 32'(lat), 3);
    chk("ab_restart_rdata", if_rdata, 32'h11112222);
    if_req = 0;
    tick();

    // Request dropped after the first access cycle
    if_req = 1; if_addr = 32'h30; mem_rdata = 32'h33334444;
    tick();
    if_req = 0;
    xfer(en, we, lat, acks, a_s, d_s);
    chk("drop_ack", 32'(acks), 32'b001);
    chk("drop_lat", 32'(lat), 2);
    chk("drop_rdata", if_rdata, 32'h33334444);
    tick();
    tick();
    chk("drop_no_regrant", 32'(busy), 0);
    chk("drop_mem_en", 32'(mem_en), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
